// File: rtl/exu_branchslv_mq_pkg.sv
// exu_branchslv_mq_pkg: shared defaults and FSM encoding for the multi-lane branch resolver
package exu_branchslv_mq_pkg;
  localparam int PC_SIZE_DEF = 32;
  localparam int XLEN_DEF = 32;
  localparam int LANES_DEF = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} brslv_st_e;
endpackage

// File: rtl/exu_branchslv_mq_tgt.sv
// exu_brslv_tgt: per-lane misprediction detect and redirect target
module exu_brslv_tgt
  import exu_branchslv_mq_pkg::*;
#(
  parameter int PC_SIZE = PC_SIZE_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic               valid,
  input  logic               bjp,
  input  logic               jalr,
  input  logic               prdt,
  input  logic               rslv,
  input  logic [PC_SIZE-1:0] pc,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    rs1,
  output logic               need_flush,
  output logic [PC_SIZE-1:0] tgt
);
  logic [XLEN-1:0] jsum;
  assign jsum = rs1 + imm;
  assign need_flush = valid & (jalr | (bjp & (prdt ^ rslv)));
  assign tgt = jalr ? {jsum[PC_SIZE-1:1], 1'b0} : rslv ? pc + imm[PC_SIZE-1:0] : pc + PC_SIZE'(4);
endmodule

// File: rtl/exu_branchslv_mq.sv
// exu_branchslv_mq: in-order multi-lane branch resolve with registered flush request and perf counters
module exu_branchslv_mq
  import exu_branchslv_mq_pkg::*;
#(
  parameter int PC_SIZE = PC_SIZE_DEF,
  parameter int XLEN = XLEN_DEF,
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         cmt_i_valid,
  output logic [LANES-1:0]         cmt_i_ready,
  input  logic [LANES-1:0]         cmt_i_bjp,
  input  logic [LANES-1:0]         cmt_i_jalr,
  input  logic [LANES-1:0]         cmt_i_bjp_prdt,
  input  logic [LANES-1:0]         cmt_i_bjp_rslv,
  input  logic [LANES*PC_SIZE-1:0] cmt_i_pc,
  input  logic [LANES*XLEN-1:0]    cmt_i_imm,
  input  logic [LANES*XLEN-1:0]    cmt_i_rs1,
  output logic                     brchmis_flush_req,
  input  logic                     brchmis_flush_ack,
  output logic [PC_SIZE-1:0]       brchmis_flush_pc,
  input  logic                     perf_clr,
  output logic [CNT_W-1:0]         perf_bjp_cnt,
  output logic [CNT_W-1:0]         perf_mis_cnt
);
  localparam int NB_W = $clog2(LANES + 1);
  logic [LANES-1:0] nf, rdy;
  logic [LANES*PC_SIZE-1:0] tgt;
  logic [PC_SIZE-1:0] sel, pc_q, pc_d;
  logic [NB_W-1:0] nb;
  logic run, hit;
  brslv_st_e st_q, st_d;
  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      exu_brslv_tgt #(.PC_SIZE(PC_SIZE), .XLEN(XLEN)) u_tgt (
        .valid(cmt_i_valid[i]),
        .bjp(cmt_i_bjp[i]),
        .jalr(cmt_i_jalr[i]),
        .prdt(cmt_i_bjp_prdt[i]),
        .rslv(cmt_i_bjp_rslv[i]),
        .pc(cmt_i_pc[i*PC_SIZE +: PC_SIZE]),
        .imm(cmt_i_imm[i*XLEN +: XLEN]),
        .rs1(cmt_i_rs1[i*XLEN +: XLEN]),
        .need_flush(nf[i]),
        .tgt(tgt[i*PC_SIZE +: PC_SIZE])
      );
    end
  endgenerate
  // Ready chain stops after an invalid or flushing lane, so at most one accepted lane can flush
  always_comb begin
    run = (st_q == ST_IDLE) & ~rst;
    rdy = '0;
    nb = '0;
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < LANES; k++) begin
      rdy[k] = run;
      if (run & cmt_i_valid[k] & (cmt_i_bjp[k] | cmt_i_jalr[k])) nb = nb + 1'b1;
      if (run & cmt_i_valid[k] & nf[k]) begin
        hit = 1'b1;
        sel = tgt[k*PC_SIZE +: PC_SIZE];
      end
      run = run & cmt_i_valid[k] & ~nf[k];
    end
  end
  // Next state: flush on an accepted mispredict, release on IFU ack
  always_comb begin
    st_d = hit ? ST_PEND : (st_q == ST_PEND && brchmis_flush_ack) ? ST_IDLE : st_q;
    pc_d = hit ? sel : pc_q;
  end
  // State, redirect PC and counters; clear beats increment
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_IDLE;
      pc_q <= '0;
      perf_bjp_cnt <= '0;
      perf_mis_cnt <= '0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      perf_bjp_cnt <= perf_clr ? '0 : perf_bjp_cnt + CNT_W'(nb);
      perf_mis_cnt <= perf_clr ? '0 : perf_mis_cnt + CNT_W'(hit);
    end
  end
  assign cmt_i_ready = rdy;
  assign brchmis_flush_req = st_q == ST_PEND;
  assign brchmis_flush_pc = pc_q;
endmodule

// File: tb/tb_exu_branchslv_mq.sv
// tb_exu_branchslv_mq: directed table plus randomized check against a spec-level model
module tb_exu_branchslv_mq;
  typedef struct {
    logic [1:0] valid, bjp, jalr, prdt, rslv;
    logic [63:0] pc, imm, rs1;
    logic ack, clr, r;
    logic [1:0] e_ready;
    logic e_req;
    logic [31:0] e_pc, e_bjp, e_mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] cmt_i_valid, cmt_i_ready, cmt_i_bjp, cmt_i_jalr, cmt_i_bjp_prdt, cmt_i_bjp_rslv;
  logic [63:0] cmt_i_pc, cmt_i_imm, cmt_i_rs1;
  logic brchmis_flush_req, brchmis_flush_ack, perf_clr;
  logic [31:0] brchmis_flush_pc, perf_bjp_cnt, perf_mis_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic m_pend;
  logic [31:0] m_pc, m_bjp, m_mis;
  vec_t tv[18];
  vec_t v;

  exu_branchslv_mq #(.PC_SIZE(32), .XLEN(32), .LANES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready),
    .cmt_i_bjp(cmt_i_bjp), .cmt_i_jalr(cmt_i_jalr),
    .cmt_i_bjp_prdt(cmt_i_bjp_prdt), .cmt_i_bjp_rslv(cmt_i_bjp_rslv),
    .cmt_i_pc(cmt_i_pc), .cmt_i_imm(cmt_i_imm), .cmt_i_rs1(cmt_i_rs1),
    .brchmis_flush_req(brchmis_flush_req), .brchmis_flush_ack(brchmis_flush_ack),
    .brchmis_flush_pc(brchmis_flush_pc),
    .perf_clr(perf_clr), .perf_bjp_cnt(perf_bjp_cnt), .perf_mis_cnt(perf_mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] va, bj, ja, pr, rs, input logic ak, cl, rr);
    vec_t t;
    t = '{default: '0};
    t.valid = va; t.bjp = bj; t.jalr = ja; t.prdt = pr; t.rslv = rs;
    t.ack = ak; t.clr = cl; t.r = rr;
    return t;
  endfunction

  function automatic vec_t ex(input vec_t t, input logic [1:0] rd, input logic rq,
                              input logic [31:0] pc, bc, mc);
    t.e_ready = rd; t.e_req = rq; t.e_pc = pc; t.e_bjp = bc; t.e_mis = mc;
    return t;
  endfunction

  function automatic bit m_nf(input vec_t t, input int k);
    return t.valid[k] && (t.jalr[k] || (t.bjp[k] && t.prdt[k] != t.rslv[k]));
  endfunction

  function automatic logic [31:0] m_tgt(input vec_t t, input int k);
    logic [31:0] pc, imm, rs1;
    pc = t.pc[k*32 +: 32]; imm = t.imm[k*32 +: 32]; rs1 = t.rs1[k*32 +: 32];
    if (t.jalr[k]) return (rs1 + imm) & 32'hFFFF_FFFE;
    return t.rslv[k] ? pc + imm : pc + 32'd4;
  endfunction

  // Lanes are taken oldest first; acceptance stops after an invalid lane or a flushing one.
  function automatic logic [1:0] m_ready(input vec_t t);
    logic [1:0] rd;
    bit go;
    rd = '0;
    if (t.r || m_pend) return rd;
    go = 1;
    for (int k = 0; k < 2; k++) begin
      rd[k] = go;
      if (!t.valid[k] || m_nf(t, k)) go = 0;
    end
    return rd;
  endfunction

  task automatic m_step(input vec_t t);
    logic [1:0] rd;
    int fl, cnt;
    rd = m_ready(t);
    fl = -1;
    cnt = 0;
    if (t.r) begin
      m_pend = 0; m_pc = 0; m_bjp = 0; m_mis = 0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (t.valid[k] && rd[k]) begin
          if (t.bjp[k] || t.jalr[k]) cnt++;
          if (m_nf(t, k) && fl < 0) fl = k;
        end
      if (m_pend) begin
        if (t.ack) m_pend = 0;
      end else if (fl >= 0) begin
        m_pend = 1; m_pc = m_tgt(t, fl); m_mis = m_mis + 1;
      end
      m_bjp = m_bjp + cnt;
      if (t.clr) begin m_bjp = 0; m_mis = 0; end
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.r;
    cmt_i_valid = t.valid; cmt_i_bjp = t.bjp; cmt_i_jalr = t.jalr;
    cmt_i_bjp_prdt = t.prdt; cmt_i_bjp_rslv = t.rslv;
    cmt_i_pc = t.pc; cmt_i_imm = t.imm; cmt_i_rs1 = t.rs1;
    brchmis_flush_ack = t.ack; perf_clr = t.clr;
  endtask

  task automatic run_cycle(input vec_t t, input bit tbl);
    drive(t);
    #1;
    chk(tbl ? "tbl_ready" : "rnd_ready", {30'd0, cmt_i_ready}, {30'd0, tbl ? t.e_ready : m_ready(t)});
    m_step(t);
    @(posedge clk);
    #1;
    chk(tbl ? "tbl_req" : "rnd_req", {31'd0, brchmis_flush_req}, {31'd0, tbl ? t.e_req : m_pend});
    chk(tbl ? "tbl_pc" : "rnd_pc", brchmis_flush_pc, tbl ? t.e_pc : m_pc);
    chk(tbl ? "tbl_bjp" : "rnd_bjp", perf_bjp_cnt, tbl ? t.e_bjp : m_bjp);
    chk(tbl ? "tbl_mis" : "rnd_mis", perf_mis_cnt, tbl ? t.e_mis : m_mis);
  endtask

  initial begin
    v = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {30'd0, cmt_i_ready}, 32'd0);
    chk("rst_req", {31'd0, brchmis_flush_req}, 32'd0);
    chk("rst_pc", brchmis_flush_pc, 32'd0);
    chk("rst_bjp", perf_bjp_cnt, 32'd0);
    chk("rst_mis", perf_mis_cnt, 32'd0);
    m_pend = 0; m_pc = 0; m_bjp = 0; m_mis = 0;

    tv[0] = ex(mk(2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 0, 0, 0), 2'b11, 0, 32'h0, 1, 0);
    v = mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 0);
    v.pc[31:0] = 32'h100; v.imm[31:0] = 32'h40;
    tv[1] = ex(v, 2'b01, 1, 32'h140, 2, 1);
    v.ack = 1;
    tv[2] = ex(v, 2'b00, 0, 32'h140, 2, 1);
    v = mk(2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    v.pc[63:32] = 32'h204;
    tv[3] = ex(v, 2'b11, 1, 32'h208, 3, 2);
    tv[4] = ex(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0), 2'b00, 0, 32'h208, 3, 2);
    v = mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    v.rs1[31:0] = 32'h1003; v.imm[31:0] = 32'h10;
    tv[5] = ex(v, 2'b01, 1, 32'h1012, 4, 3);
    for (int i = 6; i < 11; i++)
      tv[i] = ex(mk(2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 0, 0, 0), 2'b00, 1, 32'h1012, 4, 3);
    tv[11] = ex(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0), 2'b00, 0, 32'h1012, 4, 3);
    tv[12] = ex(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0), 2'b01, 0, 32'h1012, 4, 3);
    tv[13] = ex(mk(2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0), 2'b01, 0, 32'h1012, 4, 3);
    v = mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0);
    v.pc[31:0] = 32'hFFFF_FFFC;
    tv[14] = ex(v, 2'b01, 1, 32'h0, 5, 4);
    tv[15] = ex(mk(2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 1), 2'b00, 0, 32'h0, 0, 0);
    tv[16] = ex(mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 0, 1, 0), 2'b11, 0, 32'h0, 0, 0);
    tv[17] = ex(mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 0, 0, 0), 2'b11, 0, 32'h0, 1, 0);
    foreach (tv[i]) run_cycle(tv[i], 1'b1);

    for (int n = 0; n < 600; n++) begin
      v = mk(2'($urandom), 2'($urandom), {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
             2'($urandom), 2'($urandom), $urandom_range(0, 2) == 0,
             $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
      v.pc = {$urandom, $urandom};
      v.imm = {$urandom, $urandom};
      v.rs1 = {$urandom, $urandom};
      run_cycle(v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
